axis_pkt_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one AXI4-Stream datapath, the header-inserter stream input, between N_PORTS independent AXI4-Stream sources.
- Once a source is granted, the grant is held until that source's tlast beat is accepted. Packets are never interleaved.
- Output passes through a single registered slice. `m_axis_tid` tags every beat with its source index.
- Sits directly upstream of the data/header inserter in the stream path.

---
 rtl/axis_pkt_rr_arbiter_if.sv | 28 ++
 rtl/axis_pkt_rr_arbiter.sv | 92 +++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_rr_arbiter_if.sv
// rtl/axis_pkt_rr_arbiter_if.sv - stream bundle between N sources, the arbiter and the downstream sink
interface axis_pkt_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_PORTS    = 4
);
    localparam int ID_WIDTH = $clog2(N_PORTS);

    logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS-1:0]            s_axis_tready;
    logic [N_PORTS-1:0]            s_axis_tlast;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [ID_WIDTH-1:0]           m_axis_tid;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-granular round-robin stream arbiter with registered output slice
module axis_pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_PORTS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PORTS-1:0]   port_en,
    axis_pkt_rr_arbiter_if.slave axis
);
    localparam int ID_WIDTH = $clog2(N_PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   grant, grant_nxt;
    logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;
    logic [ID_WIDTH-1:0]   rr_pick;
    logic                  rr_found;
    logic [N_PORTS-1:0]    req;
    logic                  slice_can_load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    assign req            = axis.s_axis_tvalid & port_en;
    assign slice_can_load = !axis.m_axis_tvalid || axis.m_axis_tready;
    assign sel_data       = axis.s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last       = axis.s_axis_tlast[grant];

    // Search starts one past the previous winner, so that winner is visited last.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        for (int off = 1; off <= N_PORTS; off++) begin
            if (!rr_found && req[(int'(last_grant) + off) % N_PORTS]) begin
                rr_found = 1'b1;
                rr_pick  = ID_WIDTH'((int'(last_grant) + off) % N_PORTS);
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        last_grant_nxt     = last_grant;
        accept             = 1'b0;
        axis.s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                axis.s_axis_tready[grant] = slice_can_load;
                accept = axis.s_axis_tvalid[grant] && slice_can_load;
                if (accept && sel_last) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            grant              <= '0;
            last_grant         <= ID_WIDTH'(N_PORTS - 1);
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tdata  <= '0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tid    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            // Load and drain may coincide, sustaining one beat per cycle inside a packet.
            if (accept) begin
                axis.m_axis_tdata  <= sel_data;
                axis.m_axis_tlast  <= sel_last;
                axis.m_axis_tid    <= grant;
                axis.m_axis_tvalid <= 1'b1;
            end else if (axis.m_axis_tready) begin
                axis.m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - randomized scoreboard bench for the packet round-robin arbiter
module tb_axis_pkt_rr_arbiter;
    localparam int DW = 32;
    localparam int NP = 4;
    localparam int IW = $clog2(NP);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] tid;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] port_en;

    axis_pkt_rr_arbiter_if #(.DATA_WIDTH(DW), .N_PORTS(NP)) bus ();

    axis_pkt_rr_arbiter #(.DATA_WIDTH(DW), .N_PORTS(NP)) dut (
        .clk     (clk),
        .rst     (rst),
        .port_en (port_en),
        .axis    (bus.slave)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // reference model: packet ownership and output-slice occupancy
    bit    m_busy   = 1'b0;
    int    m_owner  = 0;
    int    m_last   = NP - 1;
    bit    m_ovalid = 1'b0;
    int    m_cnt    = 0;

    // source / sink driver state
    logic [NP-1:0] act, en_base, hs, in_pkt;
    int    len [NP];
    int    bidx[NP];
    int    prob, rmode, lmin, lmax, cyc;
    bit    en_rand, do_reset, rst_armed;

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] req, exp_rdy;
        bit            can_load;
        int            best_d, d;
        beat_t         b;
        if (rst) begin
            hs       = '0;
            m_busy   = 1'b0;
            m_last   = NP - 1;
            m_ovalid = 1'b0;
            m_cnt    = 0;
            exp_q.delete();
            do_reset = 1'b1;
            return;
        end
        hs       = bus.s_axis_tvalid & bus.s_axis_tready;
        can_load = !m_ovalid || bus.m_axis_tready;
        exp_rdy  = '0;
        if (m_busy && can_load) exp_rdy[m_owner] = 1'b1;
        check("s_tready", 64'(bus.s_axis_tready), 64'(exp_rdy));
        check("m_tvalid", 64'(bus.m_axis_tvalid), 64'(m_ovalid));
        req = bus.s_axis_tvalid & port_en;
        if (!m_busy) begin
            m_ovalid = m_ovalid && !bus.m_axis_tready;
            best_d = NP;
            for (int p = 0; p < NP; p++) begin
                d = (p - m_last - 1 + 2 * NP) % NP;
                if (req[p] && d < best_d) begin
                    best_d  = d;
                    m_owner = p;
                end
            end
            if (best_d < NP) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (bus.s_axis_tvalid[m_owner] && can_load) begin
            b.data = bus.s_axis_tdata[m_owner*DW +: DW];
            b.last = bus.s_axis_tlast[m_owner];
            b.tid  = IW'(m_owner);
            exp_q.push_back(b);
            m_ovalid = 1'b1;
            m_cnt++;
            if (b.last) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end else begin
            m_ovalid = m_ovalid && !bus.m_axis_tready;
        end
    endtask

    task automatic drive_step();
        if (do_reset) begin
            do_reset          = 1'b0;
            rst               = 1'b0;
            in_pkt            = '0;
            bus.s_axis_tvalid = '0;
        end else if (rst_armed && m_busy && m_cnt == 1) begin
            rst_armed = 1'b0;
            rst       = 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                bidx[p]++;
                if (bus.s_axis_tlast[p]) in_pkt[p] = 1'b0;
                bus.s_axis_tvalid[p] = 1'b0;
            end
            if (!bus.s_axis_tvalid[p]) begin
                if (!in_pkt[p] && act[p]) begin
                    in_pkt[p] = 1'b1;
                    len[p]    = int'($urandom_range(lmax, lmin));
                    bidx[p]   = 0;
                end
                if (in_pkt[p] && int'($urandom_range(99, 0)) < prob) begin
                    bus.s_axis_tvalid[p]            = 1'b1;
                    bus.s_axis_tdata[p*DW +: DW]    = $urandom;
                    bus.s_axis_tlast[p]             = (bidx[p] == len[p] - 1);
                end
            end
        end
        hs = '0;
        case (rmode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = 1'($urandom_range(1, 0));
            2:       bus.m_axis_tready = (cyc % 3 == 0);
            default: bus.m_axis_tready = ($urandom_range(99, 0) < 20);
        endcase
        port_en = en_rand ? NP'($urandom) : en_base;
        cyc++;
    endtask

    task automatic run_phase(input logic [NP-1:0] a, input logic [NP-1:0] en, input int pv,
                             input int rm, input int lo, input int hi, input int n, input bit er);
        act = a; en_base = en; prob = pv; rmode = rm; lmin = lo; lmax = hi; en_rand = er;
        repeat (n) begin
            drive_step();
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        beat_t got, held, expb;
        bit    stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                got.data = bus.m_axis_tdata;
                got.last = bus.m_axis_tlast;
                got.tid  = bus.m_axis_tid;
                if (stall) check("stall_hold", {28'd0, bus.m_axis_tvalid, got}, {28'd0, 1'b1, held});
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_beat: got %0h expected none (t=%0t)", got, $time);
                    end else begin
                        expb = exp_q.pop_front();
                        check("beat", 64'(got), 64'(expb));
                    end
                end
                stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                held  = got;
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst = 1'b1; port_en = '0; in_pkt = '0; hs = '0; cyc = 0;
        do_reset = 1'b0; rst_armed = 1'b0;
        bus.s_axis_tvalid = '0; bus.s_axis_tdata = '0; bus.s_axis_tlast = '0;
        bus.m_axis_tready = 1'b0;
        for (int p = 0; p < NP; p++) begin len[p] = 1; bidx[p] = 0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_m_tdata",  64'(bus.m_axis_tdata),  64'd0);
        check("rst_m_tlast",  64'(bus.m_axis_tlast),  64'd0);
        check("rst_m_tid",    64'(bus.m_axis_tid),    64'd0);
        check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        rst = 1'b0;

        run_phase(4'b0100, 4'b0100, 100, 0, 3, 3, 12, 1'b0);
        run_phase(4'b1011, 4'b1011, 100, 0, 2, 2, 40, 1'b0);
        run_phase(4'b0010, 4'b0011, 100, 0, 4, 4, 3, 1'b0);
        run_phase(4'b0011, 4'b0011, 100, 0, 4, 4, 20, 1'b0);
        run_phase(4'b0010, 4'b0010, 100, 2, 8, 8, 40, 1'b0);
        run_phase(4'b1111, 4'b1011, 100, 1, 1, 4, 60, 1'b0);
        run_phase(4'b1111, 4'b1011, 80, 1, 1, 5, 150, 1'b1);
        rst_armed = 1'b1;
        run_phase(4'b0011, 4'b0011, 100, 0, 4, 4, 20, 1'b0);
        run_phase(4'b1111, 4'b0000, 100, 1, 1, 3, 30, 1'b0);
        run_phase(4'b1111, 4'b1111, 70, 1, 1, 6, 600, 1'b0);
        run_phase(4'b1111, 4'b1111, 90, 3, 1, 6, 300, 1'b0);

        guard = 0;
        while ((exp_q.size() != 0 || in_pkt != '0 || m_busy || m_ovalid) && guard < 400) begin
            run_phase(4'b0000, 4'b1111, 100, 0, 1, 1, 1, 1'b0);
            guard++;
        end
        check("drain_expected_left", 64'(exp_q.size()), 64'd0);
        check("drain_busy", 64'(bus.s_axis_tready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
